// File: rtl/net_tx_arbiter.sv
// net_tx_arbiter: packet-level round-robin arbiter of N_SRC AXI-Stream sources onto one net-bound stream through a skid slice
module net_tx_arbiter #(
  parameter int N_SRC       = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                  apclk,
  input  logic                  apresetn,
  input  logic [N_SRC*64-1:0]   s_axis_tdata,
  input  logic [N_SRC*8-1:0]    s_axis_tkeep,
  input  logic [N_SRC*64-1:0]   s_axis_tuser,
  input  logic [N_SRC-1:0]      s_axis_tlast,
  input  logic [N_SRC-1:0]      s_axis_tvalid,
  output logic [N_SRC-1:0]      s_axis_tready,
  output logic [63:0]           m_axis_tdata,
  output logic [7:0]            m_axis_tkeep,
  output logic [63:0]           m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      abort_count
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} stateE;
  localparam logic [31:0] TMO = TIMEOUT_CYC;
  stateE state;
  logic [2:0] grant, ptr, arbIdx, nextPtr;
  logic [31:0] stallCnt;
  logic [CNT_W-1:0] abortCnt;
  logic [N_SRC-1:0] rot;
  logic anyValid, srcValid, readyGrant, srcAccept, abortNow, push, sliceReady;
  logic outValid, skidValid;
  logic [136:0] srcBeat, pushBeat, outBeat, skidBeat;
  assign rot = N_SRC'({s_axis_tvalid, s_axis_tvalid} >> ptr);
  always_comb begin
    anyValid = |s_axis_tvalid;
    arbIdx = ptr;
    for (int k = N_SRC - 1; k >= 0; k--)
      if (rot[k]) arbIdx = 3'((int'(ptr) + k) % N_SRC);
  end
  always_comb begin
    srcValid = 1'b0;
    srcBeat = '0;
    for (int i = 0; i < N_SRC; i++)
      if (grant == 3'(i)) begin
        srcValid = s_axis_tvalid[i];
        srcBeat = {s_axis_tdata[i*64 +: 64], s_axis_tkeep[i*8 +: 8], s_axis_tuser[i*64 +: 64], s_axis_tlast[i]};
      end
  end
  assign sliceReady = !skidValid;
  assign abortNow = (TMO != 32'd0) && (state == XFER) && (stallCnt >= TMO);
  assign readyGrant = (state == XFER) ? (sliceReady && !abortNow) : (state == DRAIN);
  assign srcAccept = srcValid && readyGrant;
  assign push = (state == XFER) && sliceReady && (abortNow || srcValid);
  assign pushBeat = abortNow ? {64'd0, 8'h01, 64'h1, 1'b1} : srcBeat;
  assign nextPtr = (grant == 3'(N_SRC - 1)) ? 3'd0 : grant + 3'd1;
  always_comb begin
    s_axis_tready = '0;
    for (int i = 0; i < N_SRC; i++)
      s_axis_tready[i] = readyGrant && (grant == 3'(i));
  end
  // the skid entry catches the one beat accepted while the output is stalled
  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      outValid <= 1'b0;
      skidValid <= 1'b0;
      outBeat <= '0;
      skidBeat <= '0;
    end else if (!outValid || m_axis_tready) begin
      outValid <= skidValid || push;
      if (skidValid) outBeat <= skidBeat;
      else if (push) outBeat <= pushBeat;
      skidValid <= 1'b0;
    end else if (push) begin
      skidBeat <= pushBeat;
      skidValid <= 1'b1;
    end
  end
  always_ff @(posedge apclk or negedge apresetn) begin
    if (!apresetn) begin
      state <= IDLE;
      grant <= 3'd0;
      ptr <= 3'd0;
      stallCnt <= 32'd0;
      abortCnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (anyValid) begin
            grant <= arbIdx;
            stallCnt <= 32'd0;
            state <= XFER;
          end
        XFER:
          if (abortNow) begin
            if (sliceReady) begin
              state <= DRAIN;
              if (!(&abortCnt)) abortCnt <= abortCnt + 1'b1;
            end
          end else if (srcAccept) begin
            stallCnt <= 32'd0;
            if (srcBeat[0]) begin
              ptr <= nextPtr;
              state <= IDLE;
            end
          end else if (!srcValid) stallCnt <= stallCnt + 32'd1;
        DRAIN:
          if (srcAccept && srcBeat[0]) begin
            ptr <= nextPtr;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = outBeat;
  assign m_axis_tvalid = outValid;
  assign grant_id = grant;
  assign busy = (state != IDLE);
  assign abort_count = abortCnt;
endmodule

// File: tb/tb_net_tx_arbiter.sv
// tb_net_tx_arbiter: directed vector table plus traffic sequences for net_tx_arbiter
module tb_net_tx_arbiter;
  logic apclk = 1'b0;
  logic apresetn = 1'b0;
  logic [255:0] sData, sUser;
  logic [31:0] sKeep;
  logic [3:0] sLast = '0, sValid = '0, sReady;
  logic [63:0] mData, mUser;
  logic [7:0] mKeep;
  logic mLast, mValid, mReady = 1'b1;
  logic [2:0] grantId;
  logic busy;
  logic [15:0] abortCount;
  logic [63:0] vD[4], vU[4];
  logic [7:0] vK[4];
  int checks = 0, failures = 0;
  typedef struct packed {logic [63:0] d; logic [7:0] k; logic [63:0] u; logic l;} beatT;
  typedef struct {
    logic [3:0] tv, tl; int b; logic mr; logic mv; int es; int eb; logic el;
    logic [3:0] erdy; logic [2:0] eg; logic ebusy;
  } rowT;
  rowT tbl[11];
  beatT got[$], expQ[$];
  int len[4], pkts[4], gapAt[4], gapLen[4], sent[4];
  logic [3:0] pat;
  for (genvar g = 0; g < 4; g++) begin : g_src
    assign sData[g*64 +: 64] = vD[g];
    assign sUser[g*64 +: 64] = vU[g];
    assign sKeep[g*8 +: 8] = vK[g];
  end
  always #5 apclk = ~apclk;
  net_tx_arbiter #(.N_SRC(4), .TIMEOUT_CYC(8), .CNT_W(16)) dut (
    .apclk(apclk), .apresetn(apresetn),
    .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tuser(sUser),
    .s_axis_tlast(sLast), .s_axis_tvalid(sValid), .s_axis_tready(sReady),
    .m_axis_tdata(mData), .m_axis_tkeep(mKeep), .m_axis_tuser(mUser),
    .m_axis_tlast(mLast), .m_axis_tvalid(mValid), .m_axis_tready(mReady),
    .grant_id(grantId), .busy(busy), .abort_count(abortCount)
  );
  function automatic logic [63:0] w(int s, int b);
    return {8'hA0 + 8'(s), 40'h0, 16'(b)};
  endfunction
  function automatic beatT mk(int s, int b, logic l);
    return '{w(s, b), 8'hF0 | 8'(s), 64'(s + 1) << 4, l};
  endfunction
  function automatic beatT cur();
    return '{mData, mKeep, mUser, mLast};
  endfunction
  task automatic chk(input string nm, input logic [136:0] act, input logic [136:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic setSrc(input int i, input int b);
    beatT x;
    logic [1:0] j;
    x = mk(i, b, 1'b0);
    j = 2'(i);
    vD[j] = x.d;
    vK[j] = x.k;
    vU[j] = x.u;
  endtask
  task automatic doReset();
    apresetn = 1'b0;
    sValid = '0;
    sLast = '0;
    mReady = 1'b1;
    repeat (2) @(posedge apclk);
    #1 apresetn = 1'b1;
  endtask
  task automatic cfg(input int s, input int l, input int p, input int ga, input int gl);
    logic [1:0] j;
    j = 2'(s);
    len[j] = l; pkts[j] = p; gapAt[j] = ga; gapLen[j] = gl;
  endtask
  task automatic clearCfg();
    for (int i = 0; i < 4; i++) cfg(i, 1, 0, -1, 0);
  endtask
  task automatic traffic(input int cycles);
    int gapLeft[4];
    logic [1:0] j;
    logic g, heldV;
    logic [3:0] acc;
    beatT held;
    heldV = 1'b0;
    held = '0;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      j = 2'(i);
      sent[j] = 0;
      gapLeft[j] = gapLen[j];
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 4; i++) begin
        j = 2'(i);
        g = (sent[j] == gapAt[j]) && (gapLeft[j] > 0);
        if (g) gapLeft[j]--;
        sValid[j] = (sent[j] < len[j] * pkts[j]) && !g;
        sLast[j] = (sent[j] % len[j]) == len[j] - 1;
        setSrc(i, sent[j]);
      end
      mReady = pat[2'(c % 4)];
      #1;
      if (heldV) begin
        chk($sformatf("hold valid c%0d", c), 137'(mValid), 137'(1));
        chk($sformatf("hold payload c%0d", c), cur(), held);
      end
      heldV = mValid && !mReady;
      held = cur();
      if (mValid && mReady) got.push_back(cur());
      acc = sValid & sReady;
      @(posedge apclk);
      #1;
      for (int i = 0; i < 4; i++) begin
        j = 2'(i);
        if (acc[j]) sent[j]++;
      end
    end
    sValid = '0;
    sLast = '0;
  endtask
  task automatic compareGot(input string nm);
    chk({nm, " beat count"}, 137'(got.size()), 137'(expQ.size()));
    for (int k = 0; k < expQ.size() && k < got.size(); k++)
      chk($sformatf("%s beat%0d", nm, k), got[k], expQ[k]);
  endtask
  initial begin
    rowT t;
    for (int i = 0; i < 4; i++) setSrc(i, 0);
    tbl[0]  = '{4'b0100, 4'b0000, 0, 1'b1, 1'b0, 0, 0, 1'b0, 4'b0000, 3'd0, 1'b0};
    tbl[1]  = '{4'b0100, 4'b0000, 0, 1'b1, 1'b0, 0, 0, 1'b0, 4'b0100, 3'd2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0000, 1, 1'b1, 1'b1, 2, 0, 1'b0, 4'b0100, 3'd2, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 2, 1'b1, 1'b1, 2, 1, 1'b0, 4'b0100, 3'd2, 1'b1};
    tbl[4]  = '{4'b0000, 4'b0000, 0, 1'b1, 1'b1, 2, 2, 1'b1, 4'b0000, 3'd2, 1'b0};
    tbl[5]  = '{4'b1001, 4'b1001, 7, 1'b1, 1'b0, 0, 0, 1'b0, 4'b0000, 3'd2, 1'b0};
    tbl[6]  = '{4'b1001, 4'b1001, 7, 1'b1, 1'b0, 0, 0, 1'b0, 4'b1000, 3'd3, 1'b1};
    tbl[7]  = '{4'b0001, 4'b0001, 7, 1'b1, 1'b1, 3, 7, 1'b1, 4'b0000, 3'd3, 1'b0};
    tbl[8]  = '{4'b0001, 4'b0001, 7, 1'b1, 1'b0, 0, 0, 1'b0, 4'b0001, 3'd0, 1'b1};
    tbl[9]  = '{4'b0000, 4'b0000, 0, 1'b1, 1'b1, 0, 7, 1'b1, 4'b0000, 3'd0, 1'b0};
    tbl[10] = '{4'b0000, 4'b0000, 0, 1'b1, 1'b0, 0, 0, 1'b0, 4'b0000, 3'd0, 1'b0};
    repeat (2) @(posedge apclk);
    #1;
    chk("reset m_tvalid", 137'(mValid), 137'(0));
    chk("reset s_tready", 137'(sReady), 137'(0));
    chk("reset grant_id", 137'(grantId), 137'(0));
    chk("reset busy", 137'(busy), 137'(0));
    chk("reset abort_count", 137'(abortCount), 137'(0));
    chk("reset m_tdata", 137'(mData), 137'(0));
    apresetn = 1'b1;
    for (int r = 0; r < 11; r++) begin
      t = tbl[r];
      for (int i = 0; i < 4; i++) setSrc(i, t.b);
      sValid = t.tv;
      sLast = t.tl;
      mReady = t.mr;
      #1;
      chk($sformatf("row%0d m_tvalid", r), 137'(mValid), 137'(t.mv));
      chk($sformatf("row%0d s_tready", r), 137'(sReady), 137'(t.erdy));
      chk($sformatf("row%0d grant_id", r), 137'(grantId), 137'(t.eg));
      chk($sformatf("row%0d busy", r), 137'(busy), 137'(t.ebusy));
      if (t.mv) chk($sformatf("row%0d payload", r), cur(), mk(t.es, t.eb, t.el));
      @(posedge apclk);
      #1;
    end
    // round robin across four always-valid sources
    doReset();
    clearCfg();
    for (int i = 0; i < 4; i++) cfg(i, 2, 2, -1, 0);
    pat = 4'b1111;
    traffic(40);
    expQ.delete();
    for (int p = 0; p < 8; p++)
      for (int b = 0; b < 2; b++) expQ.push_back(mk(p % 4, (p / 4) * 2 + b, b == 1));
    compareGot("rr");
    // output back-pressure pattern 1,0,0,1
    doReset();
    clearCfg();
    cfg(1, 16, 1, -1, 0);
    pat = 4'b1001;
    traffic(60);
    expQ.delete();
    for (int b = 0; b < 16; b++) expQ.push_back(mk(1, b, b == 15));
    compareGot("bp");
    // stall of eight cycles aborts the packet
    doReset();
    clearCfg();
    cfg(1, 5, 1, 2, 8);
    cfg(2, 1, 1, -1, 0);
    pat = 4'b1111;
    traffic(40);
    expQ.delete();
    expQ.push_back(mk(1, 0, 1'b0));
    expQ.push_back(mk(1, 1, 1'b0));
    expQ.push_back('{64'd0, 8'h01, 64'h1, 1'b1});
    expQ.push_back(mk(2, 0, 1'b1));
    compareGot("abort");
    chk("abort count", 137'(abortCount), 137'(1));
    chk("abort drained", 137'(sent[1]), 137'(5));
    chk("abort next grant", 137'(grantId), 137'(2));
    // stall of seven cycles resumes just in time
    doReset();
    clearCfg();
    cfg(1, 5, 1, 2, 7);
    cfg(2, 1, 1, -1, 0);
    traffic(40);
    expQ.delete();
    for (int b = 0; b < 5; b++) expQ.push_back(mk(1, b, b == 4));
    expQ.push_back(mk(2, 0, 1'b1));
    compareGot("noabort");
    chk("noabort count", 137'(abortCount), 137'(0));
    // asynchronous reset mid-packet, pointer must return to 0
    doReset();
    clearCfg();
    cfg(0, 1, 1, -1, 0);
    traffic(5);
    setSrc(0, 9);
    setSrc(1, 0);
    sValid = 4'b0010;
    sLast = 4'b0000;
    repeat (3) @(posedge apclk);
    #1;
    chk("pre-reset m_tvalid", 137'(mValid), 137'(1));
    chk("pre-reset s_tready", 137'(sReady), 137'(4'b0010));
    #2 apresetn = 1'b0;
    #1;
    chk("async m_tvalid", 137'(mValid), 137'(0));
    chk("async s_tready", 137'(sReady), 137'(0));
    chk("async busy", 137'(busy), 137'(0));
    @(posedge apclk);
    #1 apresetn = 1'b1;
    sValid = 4'b0011;
    sLast = 4'b0011;
    @(posedge apclk);
    #1;
    chk("post-reset grant_id", 137'(grantId), 137'(0));
    chk("post-reset s_tready", 137'(sReady), 137'(4'b0001));
    sValid = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
